// File: rtl/pwm_multichannel_if.sv
// Configuration bus from the SPI register block into the PWM core: enables, period, prescaler, duty writes.
// Latency: none (wires only). Backpressure: none, the PWM core accepts every duty write.
interface pwm_multichannel_if #(
    parameter int NUM_CH    = 16,
    parameter int CNT_WIDTH = 8,
    parameter int PRE_WIDTH = 8,
    parameter int CH_AW     = 4
);
    logic [NUM_CH-1:0]    en_out;
    logic [NUM_CH-1:0]    en_pwm;
    logic [CNT_WIDTH-1:0] period;
    logic [PRE_WIDTH-1:0] prescale;
    logic                 duty_we;
    logic [CH_AW-1:0]     duty_ch;
    logic [CNT_WIDTH-1:0] duty_data;

    modport master (
        output en_out, en_pwm, period, prescale, duty_we, duty_ch, duty_data
    );

    modport slave (
        input  en_out, en_pwm, period, prescale, duty_we, duty_ch, duty_data
    );
endinterface

// File: rtl/pwm_multichannel.sv
// Multichannel PWM, one shared prescaled counter, double-buffered per-channel duty and period.
// Latency: outputs 1 clk after cnt/duty_act, period_start 1 clk after wrap. Backpressure: none.
module pwm_multichannel #(
    parameter int NUM_CH    = 16,
    parameter int CNT_WIDTH = 8,
    parameter int PRE_WIDTH = 8,
    parameter int CH_AW     = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    pwm_multichannel_if.slave cfg,
    output logic [NUM_CH-1:0] out,
    output logic              period_start
);

    logic [PRE_WIDTH-1:0] pcnt;
    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] period_act;
    logic [CNT_WIDTH-1:0] duty_stage [NUM_CH];
    logic [CNT_WIDTH-1:0] duty_act   [NUM_CH];
    logic                 tick;
    logic                 wrap;

    // prescale is read live; a pcnt above a newly lowered prescale runs through its full range
    assign tick = (pcnt == cfg.prescale);
    assign wrap = tick && (cnt == period_act);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt <= '0;
        end else if (tick) begin
            pcnt <= '0;
        end else begin
            pcnt <= pcnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            period_act <= '0;
        end else if (wrap) begin
            cnt        <= '0;
            period_act <= cfg.period;
        end else if (tick) begin
            cnt        <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_start <= 1'b0;
        end else begin
            period_start <= wrap;
        end
    end

    // Addresses at or above NUM_CH match no channel, so such writes fall away.
    // A write on the wrap clock lands in staging only; duty_act takes the old staging value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                duty_stage[i] <= '0;
                duty_act[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (cfg.duty_we && (cfg.duty_ch == CH_AW'(i))) begin
                    duty_stage[i] <= cfg.duty_data;
                end
                if (wrap) begin
                    duty_act[i] <= duty_stage[i];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                out[i] <= cfg.en_out[i] & (~cfg.en_pwm[i] | (cnt < duty_act[i]));
            end
        end
    end

endmodule

// File: tb/tb_pwm_multichannel.sv
// Directed bench for pwm_multichannel: table of period/duty configs plus hand sequences for corner cases.
module tb_pwm_multichannel;

    localparam int NCH = 16;

    typedef struct {
        int pre;
        int per;
        int ch;
        int duty;
        int exp_n;
        int exp_hi;
    } vec_t;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [NCH-1:0] out;
    logic           period_start;

    int pass_cnt = 0;
    int total_cnt = 0;
    int meas_n;
    int hi_cnt [NCH];
    int sum;
    vec_t tbl [6];

    pwm_multichannel_if #(.NUM_CH(NCH), .CNT_WIDTH(8), .PRE_WIDTH(8), .CH_AW(5)) cfg ();

    pwm_multichannel #(.NUM_CH(NCH), .CNT_WIDTH(8), .PRE_WIDTH(8), .CH_AW(5)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cfg          (cfg),
        .out          (out),
        .period_start (period_start)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write(input int ch, input int d);
        cfg.duty_we   = 1'b1;
        cfg.duty_ch   = 5'(ch);
        cfg.duty_data = 8'(d);
        step();
        cfg.duty_we   = 1'b0;
    endtask

    task automatic wait_ps(input int lim);
        int k;
        k = 0;
        do begin
            step();
            k++;
        end while (!period_start && k < lim);
        check("wait_period_start", int'(period_start), 1);
    endtask

    // Counts clocks and per-channel high samples from one period_start to the next;
    // optionally issues a duty write on iteration wr_at (iteration k ends on edge k+1).
    task automatic measure(input int wr_at, input int ch, input int d);
        int k;
        meas_n = 0;
        for (int c = 0; c < NCH; c++) hi_cnt[c] = 0;
        k = 0;
        do begin
            if (k == wr_at) begin
                cfg.duty_we   = 1'b1;
                cfg.duty_ch   = 5'(ch);
                cfg.duty_data = 8'(d);
            end
            step();
            cfg.duty_we = 1'b0;
            meas_n++;
            for (int c = 0; c < NCH; c++) hi_cnt[c] += int'(out[c]);
            k++;
        end while (!period_start && k < 5000);
        check("measure_end", int'(period_start), 1);
    endtask

    initial begin
        tbl[0] = '{pre: 0, per: 255, ch: 0,  duty: 128, exp_n: 256, exp_hi: 128};
        tbl[1] = '{pre: 3, per: 9,   ch: 1,  duty: 5,   exp_n: 40,  exp_hi: 20};
        tbl[2] = '{pre: 0, per: 100, ch: 3,  duty: 200, exp_n: 101, exp_hi: 101};
        tbl[3] = '{pre: 0, per: 100, ch: 3,  duty: 0,   exp_n: 101, exp_hi: 0};
        tbl[4] = '{pre: 1, per: 4,   ch: 15, duty: 4,   exp_n: 10,  exp_hi: 8};
        tbl[5] = '{pre: 2, per: 0,   ch: 4,  duty: 1,   exp_n: 3,   exp_hi: 3};

        rst_n         = 1'b0;
        cfg.en_out    = '1;
        cfg.en_pwm    = '1;
        cfg.period    = 8'd255;
        cfg.prescale  = 8'd0;
        cfg.duty_we   = 1'b0;
        cfg.duty_ch   = '0;
        cfg.duty_data = '0;
        step();
        step();
        check("reset_out", int'(out), 0);
        check("reset_period_start", int'(period_start), 0);

        rst_n = 1'b1;
        write(0, 128);
        check("first_tick_wraps", int'(period_start), 1);
        measure(-1, 0, 0);
        check("first_period_len", meas_n, 256);
        check("first_period_ch0_hi", hi_cnt[0], 0);
        measure(-1, 0, 0);
        check("p256_len", meas_n, 256);
        check("p256_ch0_hi", hi_cnt[0], 128);

        for (int i = 0; i < 6; i++) begin
            cfg.prescale = 8'(tbl[i].pre);
            cfg.period   = 8'(tbl[i].per);
            write(tbl[i].ch, tbl[i].duty);
            wait_ps(5000);
            measure(-1, 0, 0);
            check($sformatf("vec%0d_len", i), meas_n, tbl[i].exp_n);
            check($sformatf("vec%0d_hi", i), hi_cnt[tbl[i].ch], tbl[i].exp_hi);
        end

        cfg.prescale = 8'd0;
        cfg.period   = 8'd255;
        write(0, 128);
        wait_ps(5000);
        measure(50, 0, 64);
        check("midwrite_cur_hi", hi_cnt[0], 128);
        measure(-1, 0, 0);
        check("midwrite_next_hi", hi_cnt[0], 64);
        measure(255, 0, 100);
        check("wrapwrite_cur_hi", hi_cnt[0], 64);
        measure(-1, 0, 0);
        check("wrapwrite_next_hi", hi_cnt[0], 64);
        measure(-1, 0, 0);
        check("wrapwrite_later_hi", hi_cnt[0], 100);

        write(0, 30);
        write(0, 77);
        wait_ps(5000);
        measure(-1, 0, 0);
        check("last_write_wins", hi_cnt[0], 77);

        cfg.en_pwm[2] = 1'b0;
        step();
        check("en_pwm_off_high", int'(out[2]), 1);
        cfg.en_out[2] = 1'b0;
        step();
        check("en_out_off_low", int'(out[2]), 0);
        cfg.en_out[2] = 1'b1;
        sum = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            sum += int'(out[2]);
        end
        check("static_high_run", sum, 20);
        cfg.en_pwm[2] = 1'b1;

        write(20, 50);
        wait_ps(5000);
        measure(-1, 0, 0);
        check("bad_ch_ch4_hi", hi_cnt[4], 1);
        check("bad_ch_ch0_hi", hi_cnt[0], 77);
        check("bad_ch_ch1_hi", hi_cnt[1], 5);

        wait_ps(5000);
        for (int k = 0; k < 5; k++) step();
        check("pre_reset_out0", int'(out[0]), 1);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_reset_out", int'(out), 0);
        check("async_reset_ps", int'(period_start), 0);
        step();
        check("held_reset_out", int'(out), 0);
        rst_n = 1'b1;
        step();
        check("post_reset_first_wrap", int'(period_start), 1);
        measure(-1, 0, 0);
        check("post_reset_len", meas_n, 256);
        sum = 0;
        for (int c = 0; c < NCH; c++) sum += hi_cnt[c];
        check("post_reset_all_low", sum, 0);
        measure(-1, 0, 0);
        check("post_reset_stage_lost", hi_cnt[0], 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
